// File: rtl/iob_native_reg_slice_if.sv
// Native bus bundle: request (valid/address/wdata/wstrb) and response (rdata/ready).
// The master modport drives the request and receives the response; the slave
// modport is the mirror image.
interface iob_native_reg_slice_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iob_native_reg_slice.sv
// Registered native-bus slice: captures one upstream request, re-issues it to the
// downstream slave from registers, registers the response and returns a one-cycle
// ready upstream. Only one transaction is ever outstanding.
// Optional watchdog enabled by defining IOB_NATIVE_SLICE_TIMEOUT_EN: a request the
// slave leaves unanswered for TIMEOUT cycles is aborted with ERR_DATA and a sticky err.
module iob_native_reg_slice #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    iob_native_reg_slice_if.slave  s,
    iob_native_reg_slice_if.master m,
    output logic                   err,
    input  logic                   err_clr
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [DATA_W-1:0]   rdata_next;
    logic                capture;
    logic                rdata_load;
    logic                abort;

`ifdef IOB_NATIVE_SLICE_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // Watchdog: counts REQ cycles without m_ready; restarts on every new capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (capture) begin
            cnt_reg <= '0;
        end else if (state_reg == REQ && !m.ready) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The TIMEOUT-th unanswered REQ cycle aborts; a same-cycle m_ready still wins.
    assign abort = (state_reg == REQ) && !m.ready && (cnt_reg == CNT_LAST);

    // Sticky error flag; an abort takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (abort) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    // Without the watchdog the slice waits forever and never flags an error.
    logic unused_cfg;
    assign unused_cfg = err_clr ^ (TIMEOUT > 0);
    assign abort      = 1'b0;
    assign err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus capture/response-load strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        rdata_load = 1'b0;
        rdata_next = '0;
        case (state_reg)
            IDLE: begin
                if (s.valid) begin
                    capture    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (m.ready) begin
                    rdata_load = 1'b1;
                    rdata_next = (wstrb_reg == '0) ? m.rdata : '0;
                    state_next = RESP;
                end else if (abort) begin
                    rdata_load = 1'b1;
                    rdata_next = ERR_DATA;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and response register; both hold between transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (capture) begin
                addr_reg  <= s.address;
                wdata_reg <= s.wdata;
                wstrb_reg <= s.wstrb;
            end
            if (rdata_load) begin
                rdata_reg <= rdata_next;
            end
        end
    end

    assign m.valid   = (state_reg == REQ);
    assign m.address = addr_reg;
    assign m.wdata   = wdata_reg;
    assign m.wstrb   = wstrb_reg;
    assign s.ready   = (state_reg == RESP);
    assign s.rdata   = rdata_reg;
endmodule

// File: tb/tb_iob_native_reg_slice.sv
// Bench for iob_native_reg_slice: directed reset check, then directed and random
// traffic against a memory-backed slave. Expected responses come from a reference
// memory updated as each request is issued; a monitor pops and compares them.
// Define IOB_NATIVE_SLICE_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=4).
module tb_iob_native_reg_slice;
`ifdef IOB_NATIVE_SLICE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int LONG_WAIT  = 3;
`else
    localparam int TB_TIMEOUT = 255;
    localparam int LONG_WAIT  = 5;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          cyc;
    } req_t;

    logic clk;
    logic rst;
    logic err;
    logic err_clr;

    iob_native_reg_slice_if #(.DATA_W(32), .ADDR_W(32)) up ();
    iob_native_reg_slice_if #(.DATA_W(32), .ADDR_W(32)) dn ();

    iob_native_reg_slice #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .TIMEOUT (TB_TIMEOUT),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s      (up),
        .m      (dn),
        .err    (err),
        .err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issues = 0;
    int n_issued = 0;
    int n_resp = 0;
    int fixed_wait = -1;
    bit slave_en = 0;
    bit mon_en = 0;

    req_t        req_q[$];
    logic [31:0] resp_q[$];
    int          rdy_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    initial clk = 0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    // Power-on content of any untouched word.
    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Byte-lane write: lanes with a strobe take new data, the others keep old data.
    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Issue one request at the current negedge, record expectations, wait for s_ready,
    // then release s_valid in the following (IDLE) cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        req_t        r;
        logic [31:0] old;
        int          n;
        up.valid   = 1'b1;
        up.address = a;
        up.wdata   = wd;
        up.wstrb   = st;
        r.addr  = a;
        r.wdata = wd;
        r.strb  = st;
        r.cyc   = cyc;
        req_q.push_back(r);
        old = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (st == 4'h0) begin
            resp_q.push_back(old);
        end else begin
            ref_mem[a] = merge(old, wd, st);
            resp_q.push_back(32'h0);
        end
        n_issued++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!up.ready && n < 64);
        if (!up.ready) chk("s_ready_timeout", 64'(up.ready), 64'(1));
        @(negedge clk);
        up.valid = 1'b0;
    endtask

    // Downstream slave: memory-backed, random or fixed wait states, and spurious
    // m_ready pulses while m_valid is low (the slice must ignore them).
    initial begin
        bit          in_txn;
        int          wait_left;
        logic [31:0] cur_addr;
        logic [31:0] cur_wdata;
        logic [3:0]  cur_strb;
        req_t        e;
        in_txn    = 0;
        wait_left = 0;
        cur_addr  = '0;
        cur_wdata = '0;
        cur_strb  = '0;
        dn.ready  = 1'b0;
        dn.rdata  = '0;
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                in_txn = 0;
                continue;
            end
            if (dn.valid) begin
                if (!in_txn) begin
                    in_txn = 1;
                    issues++;
                    cur_addr  = dn.address;
                    cur_wdata = dn.wdata;
                    cur_strb  = dn.wstrb;
                    chk("m_issue_expected", 64'(req_q.size() != 0), 64'(1));
                    if (req_q.size() != 0) begin
                        e = req_q.pop_front();
                        chk("m_address", 64'(dn.address), 64'(e.addr));
                        chk("m_wdata", 64'(dn.wdata), 64'(e.wdata));
                        chk("m_wstrb", 64'(dn.wstrb), 64'(e.strb));
                        chk("m_valid_latency", 64'(cyc), 64'(e.cyc + 1));
                    end
                    wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                end else begin
                    chk("m_address_stable", 64'(dn.address), 64'(cur_addr));
                    chk("m_wdata_stable", 64'(dn.wdata), 64'(cur_wdata));
                    chk("m_wstrb_stable", 64'(dn.wstrb), 64'(cur_strb));
                end
                if (wait_left == 0) begin
                    dn.ready = 1'b1;
                    if (cur_strb == 4'h0) begin
                        dn.rdata = slv_mem.exists(cur_addr) ? slv_mem[cur_addr] : init_val(cur_addr);
                    end else begin
                        dn.rdata = $urandom;
                        slv_mem[cur_addr] = merge(slv_mem.exists(cur_addr) ? slv_mem[cur_addr]
                                                                          : init_val(cur_addr),
                                                  cur_wdata, cur_strb);
                    end
                    rdy_q.push_back(cyc);
                    in_txn = 0;
                end else begin
                    wait_left--;
                    dn.ready = 1'b0;
                    dn.rdata = $urandom;
                end
            end else begin
                dn.ready = ($urandom_range(0, 3) == 0);
                dn.rdata = $urandom;
            end
        end
    end

    // Upstream monitor: every s_ready must match the oldest expected response and
    // arrive exactly one cycle after the slave's m_ready.
    initial forever begin
        logic [31:0] exp;
        int          rc;
        @(negedge clk);
        if (mon_en && up.ready) begin
            n_resp++;
            chk("s_ready_expected", 64'(resp_q.size() != 0), 64'(1));
            if (resp_q.size() != 0) begin
                exp = resp_q.pop_front();
                $display("txn %0d: cycle %0d s_rdata=%h expected=%h err=%0b",
                         n_resp, cyc, up.rdata, exp, err);
                chk("s_rdata", 64'(up.rdata), 64'(exp));
                chk("err_idle", 64'(err), 64'(0));
                chk("m_ready_seen", 64'(rdy_q.size() != 0), 64'(1));
                if (rdy_q.size() != 0) begin
                    rc = rdy_q.pop_front();
                    chk("s_ready_latency", 64'(cyc), 64'(rc + 1));
                end
            end
        end
    end

    initial begin
        rst        = 1'b0;
        err_clr    = 1'b0;
        up.valid   = 1'b0;
        up.address = '0;
        up.wdata   = '0;
        up.wstrb   = '0;

        // Reset state.
        @(negedge clk);
        chk("rst_m_valid", 64'(dn.valid), 64'(0));
        chk("rst_s_ready", 64'(up.ready), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_m_address", 64'(dn.address), 64'(0));
        chk("rst_s_rdata", 64'(up.rdata), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Async reset in the middle of REQ drops the transaction.
        @(negedge clk);
        up.valid   = 1'b1;
        up.address = 32'h44;
        up.wstrb   = 4'h0;
        @(negedge clk);
        chk("pre_rst_m_valid", 64'(dn.valid), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_m_valid", 64'(dn.valid), 64'(0));
        chk("async_rst_s_ready", 64'(up.ready), 64'(0));
        chk("async_rst_err", 64'(err), 64'(0));
        up.valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_s_ready", 64'(up.ready), 64'(0));
            chk("post_rst_m_valid", 64'(dn.valid), 64'(0));
        end

        slave_en = 1;
        mon_en   = 1;

        // Read with a zero-wait slave.
        ref_mem[32'h10] = 32'hCAFE_F00D;
        slv_mem[32'h10] = 32'hCAFE_F00D;
        fixed_wait = 0;
        issue(32'h10, $urandom, 4'h0);

        // Write with wait states.
        fixed_wait = LONG_WAIT;
        issue(32'h20, 32'h1234_5678, 4'hF);

        // Back-to-back alternating reads and writes, zero-wait slave.
        fixed_wait = 0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 7)) << 2);
            issue(a, $urandom, (i % 2 == 1) ? 4'(($urandom_range(1, 15))) : 4'h0);
        end

        // Random traffic with random gaps and wait states.
        fixed_wait = -1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [3:0]  st;
            a  = 32'(($urandom_range(0, 7)) << 2);
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, $urandom, st);
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_drained", 64'(resp_q.size()), 64'(0));
        chk("m_issue_count", 64'(issues), 64'(n_issued));
        chk("s_ready_count", 64'(n_resp), 64'(n_issued));

`ifdef IOB_NATIVE_SLICE_TIMEOUT_EN
        begin
            int n;
            int n_mv;
            slave_en = 0;
            mon_en   = 0;
            dn.ready = 1'b0;
            @(negedge clk);

            // Slave never answers: abort after TB_TIMEOUT cycles of m_valid.
            up.valid   = 1'b1;
            up.address = 32'h30;
            up.wstrb   = 4'h0;
            n = 0;
            n_mv = 0;
            @(negedge clk);
            while (!up.ready && n < 20) begin
                if (dn.valid) n_mv++;
                @(negedge clk);
                n++;
            end
            chk("to_m_valid_cycles", 64'(n_mv), 64'(TB_TIMEOUT));
            chk("to_s_ready", 64'(up.ready), 64'(1));
            chk("to_s_rdata", 64'(up.rdata), 64'(32'hFFFF_FFFF));
            chk("to_err_set", 64'(err), 64'(1));
            @(negedge clk);
            up.valid = 1'b0;
            dn.ready = 1'b1;
            dn.rdata = 32'h0BAD_0BAD;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("late_ready_s_ready", 64'(up.ready), 64'(0));
                chk("late_ready_m_valid", 64'(dn.valid), 64'(0));
            end
            dn.ready = 1'b0;
            chk("err_sticky", 64'(err), 64'(1));
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("err_cleared", 64'(err), 64'(0));

            // m_ready on the expiry cycle: normal response, no error.
            up.valid   = 1'b1;
            up.address = 32'h34;
            up.wstrb   = 4'h0;
            n = 0;
            n_mv = 0;
            @(negedge clk);
            while (!up.ready && n < 20) begin
                if (dn.valid) begin
                    n_mv++;
                    if (n_mv == TB_TIMEOUT) begin
                        dn.ready = 1'b1;
                        dn.rdata = 32'h1357_9BDF;
                    end
                end
                @(negedge clk);
                dn.ready = 1'b0;
                n++;
            end
            chk("expiry_m_valid_cycles", 64'(n_mv), 64'(TB_TIMEOUT));
            chk("expiry_s_ready", 64'(up.ready), 64'(1));
            chk("expiry_s_rdata", 64'(up.rdata), 64'(32'h1357_9BDF));
            chk("expiry_err_clear", 64'(err), 64'(0));
            @(negedge clk);
            up.valid = 1'b0;
            repeat (3) @(negedge clk);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
